// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared types and defaults for the register-bank arbiter
package regbank_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_WR   = 2'd2
  } req_t;

  typedef enum logic {
    SRC_I2C = 1'b0,
    SRC_AV  = 1'b1
  } src_t;

  typedef struct packed {
    req_t                  kind;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } req_s;

  // A write outranks a read when a source raises both in the same cycle
  function automatic req_t decode_req(input logic wr, input logic rd);
    return wr ? REQ_WR : (rd ? REQ_RD : REQ_NONE);
  endfunction

endpackage

// File: rtl/regbank_req_hold.sv
// rtl/regbank_req_hold.sv - 1-deep I2C request hold register with sticky overflow flag
module regbank_req_hold
  import regbank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  req_t              i_kind,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output req_t              o_kind,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow
);

  logic              r_valid;
  req_t              r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_overflow;

  // Capture an unserved request; drop it if the slot is busy and not emptying this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_kind     <= REQ_NONE;
      r_addr     <= '0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else if (i_load && r_valid && !i_drain) begin
      r_overflow <= 1'b1;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_kind  <= i_kind;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_kind     = r_kind;
  assign o_addr     = r_addr;
  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - I2C/Avalon arbiter for a single-port register bank (option: REGBANK_WR_PROTECT_EN)
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int              ADDR_W      = ADDR_W_DEF,
  parameter int              DATA_W      = DATA_W_DEF,
  parameter int              MAX_AV_WAIT = 4,
  parameter logic [ADDR_W-1:0] AV_WR_BASE = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_dataIn,
  input  logic              i2c_writeEn,
  input  logic              i2c_readReq,
  output logic [DATA_W-1:0] i2c_dataOut,
  output logic              i2c_rdValid,
  output logic              i2c_overflow,
  input  logic              avalon_read,
  input  logic              avalon_write,
  input  logic [ADDR_W-1:0] avalon_addr,
  input  logic [DATA_W-1:0] avalon_dataIn,
  output logic [DATA_W-1:0] avalon_dataOut,
  output logic              avalon_waitrequest,
  output logic              avalon_readdatavalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_AV_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_AV_WAIT);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_p1_i2c;
  logic              r_p1_av;

  req_t              w_new_kind;
  logic              w_new_valid;
  logic              w_held_valid;
  req_t              w_held_kind;
  logic [ADDR_W-1:0] w_held_addr;
  logic [DATA_W-1:0] w_held_data;
  req_t              w_cand_kind;
  logic [ADDR_W-1:0] w_cand_addr;
  logic [DATA_W-1:0] w_cand_data;
  logic              w_cand_valid;
  logic              w_av_req;
  logic              w_force;
  logic              w_av_grant;
  logic              w_i2c_grant;
  logic              w_load;
  logic              w_drain;
  logic              w_av_wr_ok;
  src_t              w_src;

  assign w_new_kind   = decode_req(i2c_writeEn, i2c_readReq);
  assign w_new_valid  = (w_new_kind != REQ_NONE);

  // The held request is older, so it is always the I2C candidate when present
  assign w_cand_kind  = w_held_valid ? w_held_kind : w_new_kind;
  assign w_cand_addr  = w_held_valid ? w_held_addr : i2c_addr;
  assign w_cand_data  = w_held_valid ? w_held_data : i2c_dataIn;
  assign w_cand_valid = w_held_valid | w_new_valid;

  assign w_av_req     = avalon_read | avalon_write;
  assign w_force      = (r_starve_cnt == CNT_MAX) & w_av_req;
  assign w_i2c_grant  = w_cand_valid & ~w_force;
  assign w_av_grant   = w_force | (~w_cand_valid & w_av_req);
  assign w_src        = w_av_grant ? SRC_AV : SRC_I2C;

  // A new request is served directly only when I2C wins and nothing is queued ahead of it
  assign w_load  = w_new_valid & ~(w_i2c_grant & ~w_held_valid);
  assign w_drain = w_i2c_grant & w_held_valid;

  assign avalon_waitrequest = w_av_req & ~w_av_grant;

`ifdef REGBANK_WR_PROTECT_EN
  assign w_av_wr_ok = (avalon_addr >= AV_WR_BASE);
`else
  logic w_unused_base;
  assign w_unused_base = ^AV_WR_BASE;
  assign w_av_wr_ok    = 1'b1;
`endif

  regbank_req_hold #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_drain    (w_drain),
    .i_kind     (w_new_kind),
    .i_addr     (i2c_addr),
    .i_data     (i2c_dataIn),
    .o_valid    (w_held_valid),
    .o_kind     (w_held_kind),
    .o_addr     (w_held_addr),
    .o_data     (w_held_data),
    .o_overflow (i2c_overflow)
  );

  // Steer the single RAM port from whichever source holds the grant
  always_comb begin
    mem_addr  = w_cand_addr;
    mem_wdata = w_cand_data;
    mem_we    = w_i2c_grant & (w_cand_kind == REQ_WR);
    if (w_src == SRC_AV) begin
      mem_addr  = avalon_addr;
      mem_wdata = avalon_dataIn;
      mem_we    = avalon_write & w_av_wr_ok;
    end
  end

  // Count consecutive stalled Avalon cycles, saturating at the forced-grant threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_av_req && !w_av_grant) begin
      if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Two-stage read return: RAM data arrives one cycle after grant, then is registered out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_i2c             <= 1'b0;
      r_p1_av              <= 1'b0;
      i2c_dataOut          <= '0;
      i2c_rdValid          <= 1'b0;
      avalon_dataOut       <= '0;
      avalon_readdatavalid <= 1'b0;
    end else begin
      r_p1_i2c             <= w_i2c_grant & (w_cand_kind == REQ_RD);
      r_p1_av              <= w_av_grant & avalon_read & ~avalon_write;
      i2c_rdValid          <= r_p1_i2c;
      avalon_readdatavalid <= r_p1_av;
      if (r_p1_i2c) i2c_dataOut    <= mem_rdata;
      if (r_p1_av)  avalon_dataOut <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - directed self-checking bench for regbank_arbiter
module tb_regbank_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_dataIn;
  logic       i2c_writeEn;
  logic       i2c_readReq;
  logic [7:0] i2c_dataOut;
  logic       i2c_rdValid;
  logic       i2c_overflow;
  logic       avalon_read;
  logic       avalon_write;
  logic [7:0] avalon_addr;
  logic [7:0] avalon_dataIn;
  logic [7:0] avalon_dataOut;
  logic       avalon_waitrequest;
  logic       avalon_readdatavalid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [7:0] ram [256];

  int checks = 0;
  int errors = 0;

  regbank_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .i2c_addr             (i2c_addr),
    .i2c_dataIn           (i2c_dataIn),
    .i2c_writeEn          (i2c_writeEn),
    .i2c_readReq          (i2c_readReq),
    .i2c_dataOut          (i2c_dataOut),
    .i2c_rdValid          (i2c_rdValid),
    .i2c_overflow         (i2c_overflow),
    .avalon_read          (avalon_read),
    .avalon_write         (avalon_write),
    .avalon_addr          (avalon_addr),
    .avalon_dataIn        (avalon_dataIn),
    .avalon_dataOut       (avalon_dataOut),
    .avalon_waitrequest   (avalon_waitrequest),
    .avalon_readdatavalid (avalon_readdatavalid),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_we               (mem_we),
    .mem_rdata            (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    i2c_addr = 8'h00; i2c_dataIn = 8'h00; i2c_writeEn = 1'b0; i2c_readReq = 1'b0;
    avalon_read = 1'b0; avalon_write = 1'b0; avalon_addr = 8'h00; avalon_dataIn = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (i2c_dataOut !== 8'h00) begin errors++; $display("FAIL reset_i2c_dataOut got %h exp 00", i2c_dataOut); end
    checks++; if (i2c_rdValid !== 1'b0) begin errors++; $display("FAIL reset_i2c_rdValid got %b exp 0", i2c_rdValid); end
    checks++; if (i2c_overflow !== 1'b0) begin errors++; $display("FAIL reset_i2c_overflow got %b exp 0", i2c_overflow); end
    checks++; if (avalon_dataOut !== 8'h00) begin errors++; $display("FAIL reset_av_dataOut got %h exp 00", avalon_dataOut); end
    checks++; if (avalon_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_av_rdv got %b exp 0", avalon_readdatavalid); end
    checks++; if (avalon_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b exp 0", avalon_waitrequest); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
  endtask

  task automatic test_i2c_wr_rd();
    i2c_addr = 8'h10; i2c_dataIn = 8'hA5; i2c_writeEn = 1'b1;
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h10, 8'hA5}) begin errors++; $display("FAIL i2c_wr_port got we=%b a=%h d=%h exp we=1 a=10 d=a5", mem_we, mem_addr, mem_wdata); end
    step();
    i2c_writeEn = 1'b0; i2c_readReq = 1'b1;
    #1;
    checks++; if ({mem_we, mem_addr} !== {1'b0, 8'h10}) begin errors++; $display("FAIL i2c_rd_port got we=%b a=%h exp we=0 a=10", mem_we, mem_addr); end
    step();
    idle();
    #1;
    checks++; if (i2c_rdValid !== 1'b0) begin errors++; $display("FAIL i2c_rdValid_n1 got %b exp 0", i2c_rdValid); end
    step();
    #1;
    checks++; if (i2c_rdValid !== 1'b1) begin errors++; $display("FAIL i2c_rdValid_n2 got %b exp 1", i2c_rdValid); end
    checks++; if (i2c_dataOut !== 8'hA5) begin errors++; $display("FAIL i2c_dataOut got %h exp a5", i2c_dataOut); end
    step();
    #1;
    checks++; if (i2c_rdValid !== 1'b0) begin errors++; $display("FAIL i2c_rdValid_pulse got %b exp 0", i2c_rdValid); end
  endtask

  task automatic test_collision();
    avalon_write = 1'b1; avalon_addr = 8'h90; avalon_dataIn = 8'h3C;
    i2c_writeEn = 1'b1; i2c_addr = 8'h90; i2c_dataIn = 8'h11;
    #1;
    checks++; if (avalon_waitrequest !== 1'b1) begin errors++; $display("FAIL coll_waitreq_n got %b exp 1", avalon_waitrequest); end
    checks++; if ({mem_we, mem_wdata} !== {1'b1, 8'h11}) begin errors++; $display("FAIL coll_i2c_first got we=%b d=%h exp we=1 d=11", mem_we, mem_wdata); end
    step();
    i2c_writeEn = 1'b0;
    #1;
    checks++; if (avalon_waitrequest !== 1'b0) begin errors++; $display("FAIL coll_waitreq_n1 got %b exp 0", avalon_waitrequest); end
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h90, 8'h3C}) begin errors++; $display("FAIL coll_av_second got we=%b a=%h d=%h exp we=1 a=90 d=3c", mem_we, mem_addr, mem_wdata); end
    step();
    idle();
    avalon_read = 1'b1; avalon_addr = 8'h90;
    #1;
    checks++; if (avalon_waitrequest !== 1'b0) begin errors++; $display("FAIL coll_rd_waitreq got %b exp 0", avalon_waitrequest); end
    step();
    idle();
    step();
    #1;
    checks++; if ({avalon_readdatavalid, avalon_dataOut} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL coll_readback got v=%b d=%h exp v=1 d=3c", avalon_readdatavalid, avalon_dataOut); end
    step();
  endtask

  task automatic test_starvation();
    logic exp_wait;
    for (int k = 0; k < 5; k++) begin
      avalon_read = 1'b1; avalon_addr = 8'h90;
      i2c_writeEn = 1'b1; i2c_addr = 8'h30 + 8'(k); i2c_dataIn = 8'(k);
      exp_wait = (k < 4);
      #1;
      checks++; if (avalon_waitrequest !== exp_wait) begin errors++; $display("FAIL starve_waitreq_%0d got %b exp %b", k, avalon_waitrequest, exp_wait); end
      if (k == 4) begin
        checks++; if ({mem_we, mem_addr} !== {1'b0, 8'h90}) begin errors++; $display("FAIL starve_forced_port got we=%b a=%h exp we=0 a=90", mem_we, mem_addr); end
      end
      step();
    end
    idle();
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h34, 8'h04}) begin errors++; $display("FAIL starve_held_drain got we=%b a=%h d=%h exp we=1 a=34 d=04", mem_we, mem_addr, mem_wdata); end
    step();
    #1;
    checks++; if ({avalon_readdatavalid, avalon_dataOut} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL starve_av_data got v=%b d=%h exp v=1 d=3c", avalon_readdatavalid, avalon_dataOut); end
    checks++; if (i2c_overflow !== 1'b0) begin errors++; $display("FAIL starve_no_overflow got %b exp 0", i2c_overflow); end
    step();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 11; k++) begin
      avalon_read = 1'b1; avalon_addr = 8'h10;
      i2c_writeEn = 1'b1; i2c_addr = 8'h40 + 8'(k); i2c_dataIn = 8'h50 + 8'(k);
      #1;
      if (k == 8) begin
        checks++; if (avalon_waitrequest !== 1'b1) begin errors++; $display("FAIL ovf_waitreq_8 got %b exp 1", avalon_waitrequest); end
      end
      if (k == 9) begin
        checks++; if (avalon_waitrequest !== 1'b0) begin errors++; $display("FAIL ovf_second_force got %b exp 0", avalon_waitrequest); end
        checks++; if (i2c_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop got %b exp 0", i2c_overflow); end
      end
      if (k == 10) begin
        checks++; if (i2c_overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_drop got %b exp 1", i2c_overflow); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h48, 8'h58}) begin errors++; $display("FAIL ovf_held_served got we=%b a=%h d=%h exp we=1 a=48 d=58", mem_we, mem_addr, mem_wdata); end
      end
      step();
    end
    idle();
    #1;
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h4A, 8'h5A}) begin errors++; $display("FAIL ovf_last_held got we=%b a=%h d=%h exp we=1 a=4a d=5a", mem_we, mem_addr, mem_wdata); end
    step();
    step();
    #1;
    checks++; if ({i2c_overflow, mem_we} !== {1'b1, 1'b0}) begin errors++; $display("FAIL ovf_sticky got ovf=%b we=%b exp ovf=1 we=0", i2c_overflow, mem_we); end
  endtask

  task automatic test_reset_midread();
    avalon_read = 1'b1; avalon_addr = 8'h10;
    #1;
    checks++; if (avalon_waitrequest !== 1'b0) begin errors++; $display("FAIL rstrd_grant got %b exp 0", avalon_waitrequest); end
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (avalon_readdatavalid !== 1'b0) begin errors++; $display("FAIL rstrd_no_valid got %b exp 0", avalon_readdatavalid); end
    checks++; if ({i2c_dataOut, avalon_dataOut} !== 16'h0000) begin errors++; $display("FAIL rstrd_data got i2c=%h av=%h exp 00 00", i2c_dataOut, avalon_dataOut); end
    checks++; if ({i2c_overflow, i2c_rdValid} !== 2'b00) begin errors++; $display("FAIL rstrd_flags got ovf=%b rdv=%b exp 0 0", i2c_overflow, i2c_rdValid); end
    step();
    #1;
    checks++; if (avalon_readdatavalid !== 1'b0) begin errors++; $display("FAIL rstrd_no_late_valid got %b exp 0", avalon_readdatavalid); end
  endtask

  task automatic test_wr_protect();
    logic       exp_we_low;
    logic [7:0] exp_low;
`ifdef REGBANK_WR_PROTECT_EN
    exp_we_low = 1'b0; exp_low = 8'h00;
`else
    exp_we_low = 1'b1; exp_low = 8'hFF;
`endif
    avalon_write = 1'b1; avalon_addr = 8'h20; avalon_dataIn = 8'hFF;
    #1;
    checks++; if ({avalon_waitrequest, mem_we} !== {1'b0, exp_we_low}) begin errors++; $display("FAIL prot_low_write got wr=%b we=%b exp wr=0 we=%b", avalon_waitrequest, mem_we, exp_we_low); end
    step();
    avalon_addr = 8'h80;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL prot_high_write got %b exp 1", mem_we); end
    step();
    idle();
    avalon_read = 1'b1; avalon_addr = 8'h20;
    step();
    idle();
    step();
    #1;
    checks++; if ({avalon_readdatavalid, avalon_dataOut} !== {1'b1, exp_low}) begin errors++; $display("FAIL prot_readback got v=%b d=%h exp v=1 d=%h", avalon_readdatavalid, avalon_dataOut, exp_low); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_i2c_wr_rd();
    test_collision();
    test_starvation();
    test_overflow();
    test_reset_midread();
    test_wr_protect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
Shares one single-port 256x8 register bank between the I2C slave register path and the Avalon-MM slave port.
- Performs at most one memory access per cycle.
- I2C has fixed priority and is never stalled; a 1-deep hold register absorbs a blocked I2C request.
- Avalon is stalled with waitrequest and protected from starvation by a wait counter.
- Sits between the I2C slave core / Avalon fabric and the register-bank RAM.

Parameters:
ADDR_W, 8, address width (bank depth 2**ADDR_W)
DATA_W, 8, data width
MAX_AV_WAIT, 4, consecutive stalled Avalon cycles before Avalon is forced a grant (>=1)
AV_WR_BASE, 8'h80, lowest Avalon-writable address (used only with REGBANK_WR_PROTECT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i2c_addr  in  ADDR_W  I2C access address
i2c_dataIn  in  DATA_W  I2C write data
i2c_writeEn  in  1  1-cycle I2C write request pulse
i2c_readReq  in  1  1-cycle I2C read request pulse
i2c_dataOut  out  DATA_W  I2C read data
i2c_rdValid  out  1  1-cycle pulse, i2c_dataOut valid
i2c_overflow  out  1  sticky: I2C request dropped
avalon_read  in  1  Avalon read request
avalon_write  in  1  Avalon write request
avalon_addr  in  ADDR_W  Avalon address
avalon_dataIn  in  DATA_W  Avalon write data
avalon_dataOut  out  DATA_W  Avalon read data
avalon_waitrequest  out  1  Avalon stall
avalon_readdatavalid  out  1  1-cycle pulse, avalon_dataOut valid
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  DATA_W  RAM read data, valid one cycle after address presented

Behaviour:
- Reset values:
  - All registered outputs 0: i2c_dataOut, i2c_rdValid, i2c_overflow, avalon_dataOut, avalon_readdatavalid.
  - Hold register empty; starvation counter 0; read pipeline cleared.
  - Reset mid-operation discards in-flight reads (no valid pulse) and any held I2C request.
- I2C request: i2c_writeEn or i2c_readReq. If both are high, the write wins.
- I2C candidate each cycle: the held request if present, otherwise the new request.
- Avalon request: avalon_read or avalon_write. If both are high, the write wins.
- Grant rule, per cycle:
  - If starve_cnt == MAX_AV_WAIT and Avalon is requesting, grant Avalon.
  - Otherwise, if an I2C candidate exists, grant I2C.
  - Otherwise, if Avalon is requesting, grant Avalon.
- Hold register:
  - A new I2C request that is not served this cycle (forced Avalon grant, or held request served first) loads the hold register.
  - If the hold register is already occupied and not draining this cycle, the new request is dropped and i2c_overflow sets (cleared only by rst).
  - Held request and new request both present: the held one is served first, and the new one replaces it in the hold register.
- avalon_waitrequest is combinational: (avalon_read | avalon_write) & ~av_grant. Avalon must hold its request while stalled.
- starve_cnt:
  - Increments each cycle Avalon requests and is stalled, saturating at MAX_AV_WAIT.
  - Clears on Avalon grant or when there is no Avalon request.
- Memory port: mem_addr, mem_wdata and mem_we are driven combinationally from the granted request. mem_we = granted write.
- Read latency, with grant in cycle N:
  - mem_rdata is valid in cycle N+1.
  - It is registered into i2c_dataOut or avalon_dataOut, and the matching valid pulse is high in cycle N+2.
  - Back-to-back reads are fully pipelined.
- Same-address collision: I2C and Avalon writes in the same cycle are serialized, I2C first. The Avalon value is final.
- A read granted in the cycle after a write to the same address returns the new data.

Optional Feature:
REGBANK_WR_PROTECT_EN
- Defined: an Avalon write with avalon_addr < AV_WR_BASE is accepted (waitrequest low for one cycle) but mem_we stays 0. I2C writes are unrestricted.
- Undefined: all Avalon writes reach memory; AV_WR_BASE is unused.

Decomposition:
- Package regbank_pkg:
  - ADDR_W and DATA_W defaults.
  - req_t enum: REQ_NONE, REQ_RD, REQ_WR.
  - src_t enum: SRC_I2C, SRC_AV.
  - Request struct: type, addr, data.
- One natural sub-module: regbank_req_hold, the 1-deep I2C hold register with overflow flag.

Test Plan:
- I2C write 0x10<=0xA5, then I2C read 0x10 -> mem_we in the grant cycle; i2c_rdValid two cycles after the read grant with i2c_dataOut=0xA5.
- Avalon write 0x90<=0x3C and I2C write 0x90<=0x11 in the same cycle -> I2C write cycle N, Avalon cycle N+1 with waitrequest high at N; a later read of 0x90 returns 0x3C.
- Avalon read held while I2C writes every cycle -> waitrequest high for exactly 4 cycles, forced grant on the 5th; the blocked I2C request is held and served next cycle; i2c_overflow stays 0.
- Three I2C requests on consecutive cycles during the forced Avalon grant plus held drain -> third request dropped, i2c_overflow=1 until rst.
- rst asserted one cycle after an Avalon read grant -> no avalon_readdatavalid pulse; all outputs 0 the cycle after reset.
- With REGBANK_WR_PROTECT_EN: Avalon write 0x20<=0xFF -> accepted, mem_we=0, readback unchanged; write 0x80<=0xFF -> mem_we=1.
